led_pattern_sequencer: RTL and testbench

Controller that sequences the board LEDs through selectable blink patterns at a programmable step rate. It replaces free-running per-LED toggle counters with one prescaler, one step scheduler and a pattern state machine. Commands (mode and rate) arrive over a valid/ready handshake from a button debouncer or host logic. A new command can preempt the running pattern at any time.

---
 rtl/led_pattern_sequencer_if.sv | 11 +
 rtl/led_pattern_sequencer.sv | 155 +++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_sequencer_if.sv
// Command handshake between a requester (button debouncer or host logic) and the LED sequencer.
// Each command carries a pattern mode and a step rate.
interface led_pattern_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_mode;
   logic [3:0] cmd_rate;

   modport master (output cmd_valid, output cmd_mode, output cmd_rate, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_mode, input cmd_rate, output cmd_ready);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Steps the board LEDs through a selectable blink pattern, using one shared prescaler and a
// per-command rate divider. A newly accepted command preempts whatever pattern is running.
module led_pattern_sequencer #(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned TICK_HZ  = 10,
   parameter int unsigned NUM_LEDS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   led_pattern_sequencer_if.slave  cmd,
   output logic [NUM_LEDS-1:0]     o_leds,
   output logic                    o_step_pulse
);

   localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);
   // Repeating 01 and truncating leaves bit0=1, bit1=0, ... for any LED count.
   localparam logic [NUM_LEDS-1:0] ALT_INIT  = NUM_LEDS'({((NUM_LEDS + 1) / 2){2'b01}});

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
   typedef enum logic [2:0] {
      ModeOff, ModeOn, ModeBlink, ModeChase, ModeBounce, ModeCount, ModeAlt, ModeRsvd
   } mode_e;

   state_e              r_state, w_state_next;
   mode_e               r_mode, w_mode_next;
   logic [3:0]          r_rate, w_rate_next;
   logic [3:0]          r_rate_cnt, w_rate_cnt_next;
   logic [PRESC_W-1:0]  r_presc, w_presc_next;
   logic                r_dir_down, w_dir_down_next;
   logic [NUM_LEDS-1:0] r_leds, w_leds_next;
   logic                r_step, w_step_next;
   logic                w_ready;
   logic                w_accept;

   function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_e mode);
      logic [NUM_LEDS-1:0] p;
      p = '0;
      case (mode)
         ModeOn, ModeBlink:     p = '1;
         ModeChase, ModeBounce: p = NUM_LEDS'(1);
         ModeAlt:               p = ALT_INIT;
         default:               p = '0;
      endcase
      return p;
   endfunction

   assign w_ready       = (r_state != StLoad);
   assign w_accept      = cmd.cmd_valid & w_ready;
   assign cmd.cmd_ready = w_ready;
   assign o_leds        = r_leds;
   assign o_step_pulse  = r_step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_mode     <= ModeOff;
         r_rate     <= '0;
         r_rate_cnt <= '0;
         r_presc    <= '0;
         r_dir_down <= 1'b0;
         r_leds     <= '0;
         r_step     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_mode     <= w_mode_next;
         r_rate     <= w_rate_next;
         r_rate_cnt <= w_rate_cnt_next;
         r_presc    <= w_presc_next;
         r_dir_down <= w_dir_down_next;
         r_leds     <= w_leds_next;
         r_step     <= w_step_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_mode_next     = r_mode;
      w_rate_next     = r_rate;
      w_rate_cnt_next = r_rate_cnt;
      w_presc_next    = r_presc;
      w_dir_down_next = r_dir_down;
      w_leds_next     = r_leds;
      w_step_next     = 1'b0;

      unique case (r_state)
         StIdle: begin
            w_leds_next = '0;
            if (w_accept) begin
               w_mode_next  = mode_e'(cmd.cmd_mode);
               w_rate_next  = cmd.cmd_rate;
               w_state_next = StLoad;
            end
         end
         StLoad: begin
            w_presc_next    = '0;
            w_rate_cnt_next = '0;
            w_dir_down_next = 1'b0;
            if (r_mode == ModeOff || r_mode == ModeRsvd) begin
               w_state_next = StIdle;
               w_leds_next  = '0;
            end else begin
               w_state_next = StRun;
               w_leds_next  = init_pattern(r_mode);
            end
         end
         StRun: begin
            if (w_accept) begin
               // Preemption drops all timing progress and suppresses any coincident step.
               w_mode_next     = mode_e'(cmd.cmd_mode);
               w_rate_next     = cmd.cmd_rate;
               w_presc_next    = '0;
               w_rate_cnt_next = '0;
               w_state_next    = StLoad;
            end else if (r_presc != PRESC_MAX) begin
               w_presc_next = r_presc + PRESC_W'(1);
            end else begin
               w_presc_next = '0;
               if (r_rate_cnt != r_rate) begin
                  w_rate_cnt_next = r_rate_cnt + 4'd1;
               end else begin
                  w_rate_cnt_next = '0;
                  w_step_next     = 1'b1;
                  case (r_mode)
                     ModeBlink, ModeAlt: w_leds_next = ~r_leds;
                     ModeChase: w_leds_next = (r_leds << 1) | (r_leds >> (NUM_LEDS - 1));
                     ModeCount: w_leds_next = r_leds + NUM_LEDS'(1);
                     ModeBounce: begin
                        if (NUM_LEDS > 1) begin
                           if (!r_dir_down) begin
                              if (r_leds[NUM_LEDS-1]) begin
                                 w_dir_down_next = 1'b1;
                                 w_leds_next     = r_leds >> 1;
                              end else begin
                                 w_leds_next = r_leds << 1;
                              end
                           end else if (r_leds[0]) begin
                              w_dir_down_next = 1'b0;
                              w_leds_next     = r_leds << 1;
                           end else begin
                              w_leds_next = r_leds >> 1;
                           end
                        end
                     end
                     default: w_leds_next = r_leds;
                  endcase
               end
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for the LED sequencer with TICK_DIV=10 and four LEDs; outputs are sampled on
// the falling edge, stimulus changes on the falling edge.
module tb_led_pattern_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] leds;
   logic       step_pulse;
   int         n_vec = 0;
   int         n_err = 0;

   led_pattern_sequencer_if cmd_if ();

   led_pattern_sequencer #(.CLK_HZ(100), .TICK_HZ(10), .NUM_LEDS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd          (cmd_if),
      .o_leds       (leds),
      .o_step_pulse (step_pulse)
   );

   always #5 clk = ~clk;

   // Ends on the falling edge after the accept edge.
   task automatic send_cmd(input logic [2:0] m, input logic [3:0] r);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_mode  = m;
      cmd_if.cmd_rate  = r;
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(negedge clk);
         if (step_pulse === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset();
      int p;
      int bad;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_mode  = 3'd0;
      cmd_if.cmd_rate  = 4'd0;
      rst = 1'b1;
      #12;
      n_vec++; if (leds !== 4'b0000) begin n_err++; $display("FAIL rst_leds got=%b exp=0000", leds); end
      n_vec++; if (step_pulse !== 1'b0) begin n_err++; $display("FAIL rst_step got=%b exp=0", step_pulse); end
      n_vec++; if (cmd_if.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", cmd_if.cmd_ready); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (cmd_if.cmd_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got=%b exp=1", cmd_if.cmd_ready); end
      p = 0;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (step_pulse === 1'b1) p++;
         if (leds !== 4'b0000 || cmd_if.cmd_ready !== 1'b1) bad++;
      end
      n_vec++; if (p !== 0) begin n_err++; $display("FAIL idle_pulses got=%0d exp=0", p); end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL idle_outputs bad_cycles=%0d exp=0", bad); end
   endtask

   task automatic test_chase(input string tag);
      logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      int p;
      send_cmd(3'd3, 4'd0);
      n_vec++; if (cmd_if.cmd_ready !== 1'b0) begin n_err++; $display("FAIL %s_load_ready got=%b exp=0", tag, cmd_if.cmd_ready); end
      @(negedge clk);
      n_vec++; if (leds !== 4'b0001) begin n_err++; $display("FAIL %s_init got=%b exp=0001", tag, leds); end
      n_vec++; if (cmd_if.cmd_ready !== 1'b1 || step_pulse !== 1'b0) begin
         n_err++; $display("FAIL %s_run_entry ready=%b step=%b exp ready=1 step=0", tag, cmd_if.cmd_ready, step_pulse);
      end
      for (int s = 0; s < 4; s++) begin
         wait_cycles(9, p);
         @(negedge clk);
         n_vec++; if (leds !== exp_seq[s] || step_pulse !== 1'b1 || p !== 0) begin
            n_err++; $display("FAIL %s_step%0d leds=%b step=%b early=%0d exp leds=%b step=1 early=0", tag, s, leds, step_pulse, p, exp_seq[s]);
         end
      end
   endtask

   task automatic test_bounce();
      logic [3:0] exp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      int p;
      send_cmd(3'd4, 4'd2);
      @(negedge clk);
      n_vec++; if (leds !== 4'b0001) begin n_err++; $display("FAIL bounce_init got=%b exp=0001", leds); end
      for (int s = 0; s < 7; s++) begin
         wait_cycles(29, p);
         @(negedge clk);
         n_vec++; if (leds !== exp_seq[s] || step_pulse !== 1'b1 || p !== 0) begin
            n_err++; $display("FAIL bounce_step%0d leds=%b step=%b early=%0d exp leds=%b step=1 early=0", s, leds, step_pulse, p, exp_seq[s]);
         end
      end
   endtask

   task automatic test_count();
      int p;
      int total;
      logic [3:0] exp_leds;
      send_cmd(3'd5, 4'd0);
      @(negedge clk);
      n_vec++; if (leds !== 4'b0000) begin n_err++; $display("FAIL count_init got=%b exp=0000", leds); end
      total = 0;
      exp_leds = 4'd0;
      for (int s = 1; s <= 17; s++) begin
         wait_cycles(9, p);
         total += p;
         @(negedge clk);
         if (step_pulse === 1'b1) total++;
         exp_leds = exp_leds + 4'd1;
         n_vec++; if (leds !== exp_leds) begin n_err++; $display("FAIL count_step%0d got=%b exp=%b", s, leds, exp_leds); end
      end
      n_vec++; if (total !== 17) begin n_err++; $display("FAIL count_pulses got=%0d exp=17", total); end
   endtask

   task automatic test_preempt();
      int p;
      send_cmd(3'd2, 4'd0);
      @(negedge clk);
      n_vec++; if (leds !== 4'b1111) begin n_err++; $display("FAIL blink_init got=%b exp=1111", leds); end
      wait_cycles(9, p);
      // Prescaler now sits at its terminal count: the next edge would step.
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_mode  = 3'd0;
      cmd_if.cmd_rate  = 4'd0;
      @(negedge clk);
      n_vec++; if (leds !== 4'b1111 || step_pulse !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
         n_err++; $display("FAIL preempt_edge leds=%b step=%b ready=%b exp 1111/0/0", leds, step_pulse, cmd_if.cmd_ready);
      end
      cmd_if.cmd_mode = 3'd3;
      @(negedge clk);
      n_vec++; if (leds !== 4'b0000 || cmd_if.cmd_ready !== 1'b1 || step_pulse !== 1'b0) begin
         n_err++; $display("FAIL off_idle leds=%b ready=%b step=%b exp 0000/1/0", leds, cmd_if.cmd_ready, step_pulse);
      end
      @(negedge clk);
      n_vec++; if (cmd_if.cmd_ready !== 1'b0 || leds !== 4'b0000) begin
         n_err++; $display("FAIL held_accept ready=%b leds=%b exp 0/0000", cmd_if.cmd_ready, leds);
      end
      cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (leds !== 4'b0001) begin n_err++; $display("FAIL held_chase_init got=%b exp=0001", leds); end
   endtask

   task automatic test_async_reset();
      int p;
      send_cmd(3'd6, 4'd1);
      #2 rst = 1'b1;
      #1;
      n_vec++; if (leds !== 4'b0000 || step_pulse !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_mid_load leds=%b step=%b ready=%b exp 0000/0/1", leds, step_pulse, cmd_if.cmd_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      wait_cycles(25, p);
      n_vec++; if (p !== 0 || leds !== 4'b0000) begin
         n_err++; $display("FAIL rst_load_discard pulses=%0d leds=%b exp 0/0000", p, leds);
      end
      send_cmd(3'd6, 4'd1);
      @(negedge clk);
      n_vec++; if (leds !== 4'b0101) begin n_err++; $display("FAIL alt_init got=%b exp=0101", leds); end
      wait_cycles(19, p);
      @(negedge clk);
      n_vec++; if (leds !== 4'b1010 || step_pulse !== 1'b1 || p !== 0) begin
         n_err++; $display("FAIL alt_step leds=%b step=%b early=%0d exp 1010/1/0", leds, step_pulse, p);
      end
      wait_cycles(15, p);
      #2 rst = 1'b1;
      #1;
      n_vec++; if (leds !== 4'b0000 || step_pulse !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_run leds=%b step=%b exp 0000/0", leds, step_pulse);
      end
      @(negedge clk);
      rst = 1'b0;
      test_chase("post_reset");
   endtask

   initial begin
      test_reset();
      test_chase("chase");
      test_bounce();
      test_count();
      test_preempt();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
